// File: rtl/fir_pkg.sv
// Shared definitions for the FIR decimator: default sample width, the clog2
// helper and the legal-value checks for the decimation ratio and FIFO depth.
package fir_pkg;

  localparam int DATA_WIDTH_DEF = 24;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit decim_legal(input int d);
    return is_pow2(d) && (d >= 1) && (d <= 64);
  endfunction

  function automatic bit fifo_depth_legal(input int d);
    return is_pow2(d) && (d >= 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter.
// The head entry is presented combinationally and reads as zero when empty.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr,
  input  logic [WIDTH-1:0]        iv_wdata,
  input  logic                    i_rd,
  output logic [WIDTH-1:0]        ov_rdata,
  output logic                    o_valid,
  output logic [clog2(DEPTH):0]   ov_level,
  output logic                    o_drop
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    level;
  logic             empty;
  logic             full;
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_ok = i_rd & ~empty;
  // A pop on the same edge frees the slot the push lands in, so full+read still accepts.
  assign wr_ok  = i_wr & (~full | rd_ok);
  assign o_drop = i_wr & full & ~rd_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr] <= iv_wdata;
  end

  assign ov_rdata = empty ? '0 : mem[rptr];
  assign o_valid  = ~empty;
  assign ov_level = level;

endmodule

// File: rtl/fir_decimator.sv
// Boxcar-averaging decimator: sums DECIM accepted samples, shifts by log2(DECIM)
// (truncation toward minus infinity) and buffers the results in a small FIFO.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic signed [DATA_WIDTH-1:0]  iv_din,
  input  logic                          i_din_valid,
  output logic signed [DATA_WIDTH-1:0]  ov_dout,
  output logic                          o_dout_valid,
  input  logic                          i_dout_ready,
  output logic [clog2(FIFO_DEPTH):0]    ov_level,
  output logic                          o_overflow,
  input  logic                          i_clr_ovf
);

  localparam int LOG2D = clog2(DECIM);
  localparam int PH_W  = (LOG2D > 0) ? LOG2D : 1;
  localparam int ACC_W = DATA_WIDTH + LOG2D;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  if (!decim_legal(DECIM)) begin : g_bad_decim
    $error("fir_decimator: DECIM must be a power of two in 1..64");
  end
  if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_depth
    $error("fir_decimator: FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic signed [DATA_WIDTH-1:0] trunc_avg(
    input logic signed [ACC_W-1:0] s
  );
    logic signed [ACC_W-1:0] sh;
    sh = s >>> LOG2D;
    return sh[DATA_WIDTH-1:0];
  endfunction

  logic                    vld_p0;
  logic                    last_p0;
  logic [PH_W-1:0]         phase_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] sum_p0;
  logic                    wr_p1;
  logic signed [DATA_WIDTH-1:0] avg_p1;
  logic [DATA_WIDTH-1:0]   fifo_rdata;
  logic                    fifo_drop;

  // Stage p0: accept, accumulate; phase 0 restarts the sum instead of adding.
  assign vld_p0   = i_en & i_din_valid;
  assign last_p0  = (phase_p0 == PH_LAST);
  assign din_ext  = ACC_W'(iv_din);
  assign acc_base = (phase_p0 == '0) ? '0 : acc_p0;
  assign sum_p0   = acc_base + din_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_p0 <= '0;
      acc_p0   <= '0;
    end else if (vld_p0) begin
      phase_p0 <= last_p0 ? '0 : phase_p0 + PH_W'(1);
      acc_p0   <= sum_p0;
    end
  end

  // Stage p1: completed group result enters the FIFO on the same edge.
  assign wr_p1  = vld_p0 & last_p0;
  assign avg_p1 = trunc_avg(sum_p0);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr     (wr_p1),
    .iv_wdata (avg_p1),
    .i_rd     (i_dout_ready),
    .ov_rdata (fifo_rdata),
    .o_valid  (o_dout_valid),
    .ov_level (ov_level),
    .o_drop   (fifo_drop)
  );

  assign ov_dout = fifo_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (fifo_drop) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: a DECIM=4 instance for averaging, overflow and
// reset scenarios, and a DECIM=2 instance for gap and enable handling.
module tb_fir_decimator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic               en4 = 1'b0, dv4 = 1'b0, rdy4 = 1'b0, clr4 = 1'b0;
  logic signed [23:0] din4 = '0;
  logic signed [23:0] dout4;
  logic               dvld4, ovf4;
  logic [2:0]         lvl4;

  logic               en2 = 1'b0, dv2 = 1'b0, rdy2 = 1'b0, clr2 = 1'b0;
  logic signed [23:0] din2 = '0;
  logic signed [23:0] dout2;
  logic               dvld2, ovf2;
  logic [2:0]         lvl2;

  int checks = 0;
  int failures = 0;

  fir_decimator #(.DATA_WIDTH(24), .DECIM(4), .FIFO_DEPTH(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .iv_din(din4), .i_din_valid(dv4),
    .ov_dout(dout4), .o_dout_valid(dvld4), .i_dout_ready(rdy4),
    .ov_level(lvl4), .o_overflow(ovf4), .i_clr_ovf(clr4)
  );

  fir_decimator #(.DATA_WIDTH(24), .DECIM(2), .FIFO_DEPTH(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .iv_din(din2), .i_din_valid(dv2),
    .ov_dout(dout2), .o_dout_valid(dvld2), .i_dout_ready(rdy2),
    .ov_level(lvl2), .o_overflow(ovf2), .i_clr_ovf(clr2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input int v);
    din4 = 24'(v);
    dv4  = 1'b1;
    tick();
    dv4  = 1'b0;
  endtask

  task automatic feed2(input int v);
    din2 = 24'(v);
    dv2  = 1'b1;
    tick();
    dv2  = 1'b0;
  endtask

  task automatic grp4(input int v);
    for (int i = 0; i < 4; i++) feed4(v);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", dvld4, 0);
    chk("rst_dout", dout4, 0);
    chk("rst_level", lvl4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_valid_d2", dvld2, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic average 4,8,12,16 -> 10
    en4 = 1'b1;
    rdy4 = 1'b1;
    feed4(4);
    feed4(8);
    feed4(12);
    chk("basic_no_early_valid", dvld4, 0);
    feed4(16);
    chk("basic_valid", dvld4, 1);
    chk("basic_dout", dout4, 10);
    tick();
    chk("basic_popped", dvld4, 0);

    // Negative truncation: -5 >>> 2 = -2
    rdy4 = 1'b0;
    feed4(-1);
    feed4(-1);
    feed4(-1);
    feed4(-2);
    chk("neg_dout", dout4, -2);
    chk("neg_level", lvl4, 1);
    rdy4 = 1'b1;
    tick();
    chk("neg_drained", lvl4, 0);
    rdy4 = 1'b0;

    // Gap tolerance and enable gating on DECIM=2
    en2 = 1'b1;
    rdy2 = 1'b1;
    feed2(100);
    tick();
    tick();
    tick();
    chk("gap_no_output", dvld2, 0);
    en2 = 1'b0;
    feed2(999);
    chk("en_low_ignored", dvld2, 0);
    en2 = 1'b1;
    feed2(50);
    chk("gap_valid", dvld2, 1);
    chk("gap_dout", dout2, 75);
    tick();
    chk("gap_popped", dvld2, 0);

    // Overflow: five groups into a depth-4 FIFO with no reads
    grp4(10);
    grp4(20);
    grp4(30);
    grp4(40);
    chk("full_level", lvl4, 4);
    chk("full_no_ovf", ovf4, 0);
    grp4(50);
    chk("ovf_level", lvl4, 4);
    chk("ovf_set", ovf4, 1);
    chk("ovf_head", dout4, 10);

    // Drop and clear on the same edge: drop wins
    feed4(60);
    feed4(60);
    feed4(60);
    clr4 = 1'b1;
    feed4(60);
    chk("drop_beats_clear", ovf4, 1);
    tick();
    clr4 = 1'b0;
    chk("clear_ovf", ovf4, 0);

    // Full FIFO with simultaneous write and read
    feed4(70);
    feed4(70);
    feed4(70);
    rdy4 = 1'b1;
    feed4(70);
    chk("wr_rd_full_level", lvl4, 4);
    chk("wr_rd_full_no_ovf", ovf4, 0);
    chk("drain_0", dout4, 20);
    tick();
    chk("drain_1", dout4, 30);
    tick();
    chk("drain_2", dout4, 40);
    tick();
    chk("drain_3", dout4, 70);
    tick();
    chk("drain_empty", dvld4, 0);
    chk("drain_level", lvl4, 0);

    // Mid-group reset with a pending entry in the FIFO
    rdy4 = 1'b0;
    grp4(3);
    chk("pre_rst_level", lvl4, 1);
    feed4(5);
    feed4(5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", dvld4, 0);
    chk("midrst_dout", dout4, 0);
    chk("midrst_level", lvl4, 0);
    tick();
    rst_n = 1'b1;
    rdy4 = 1'b1;
    feed4(1);
    feed4(1);
    chk("fresh_no_early", dvld4, 0);
    feed4(1);
    chk("fresh_no_early3", dvld4, 0);
    feed4(1);
    chk("fresh_valid", dvld4, 1);
    chk("fresh_dout", dout4, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter DATA_WIDTH, default 24: sample width, signed two's complement, matches the upstream FIR output.
REQ-002 Parameter DECIM, default 4: decimation ratio; legal values are powers of two from 1 to 64.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer entries; legal values are powers of two of at least 2.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port i_clk, input, 1: sole clock; all state changes on the rising edge.
REQ-006 Port i_rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port i_en, input, 1: input-side enable; when low, input samples are ignored.
REQ-008 Port iv_din, input, DATA_WIDTH: FIR output sample, signed.
REQ-009 Port i_din_valid, input, 1: iv_din qualifier; there is no backpressure toward the FIR.
REQ-010 Port ov_dout, output, DATA_WIDTH: decimated (boxcar-averaged) sample, signed.
REQ-011 Port o_dout_valid, output, 1: FIFO non-empty; ov_dout is valid.
REQ-012 Port i_dout_ready, input, 1: consumer accepts ov_dout in any cycle where o_dout_valid and i_dout_ready are both high.
REQ-013 Port ov_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-014 Port o_overflow, output, 1: sticky flag set when a result is dropped.
REQ-015 Port i_clr_ovf, input, 1: synchronous clear for o_overflow.

Function
REQ-016 Accepted input: a cycle with i_en=1 and i_din_valid=1; all other cycles leave the phase counter and accumulator unchanged.
REQ-017 Phase counter: 0..DECIM-1; increments per accepted input and wraps to 0 after DECIM-1.
REQ-018 Accumulator width: DATA_WIDTH+log2(DECIM), signed, sign-extended adds; overflow is impossible by construction.
REQ-019 Phase 0 accepted input: the accumulator loads the sign-extended iv_din, discarding the prior sum.
REQ-020 Phases 1..DECIM-1 accepted input: the accumulator adds the sign-extended iv_din.
REQ-021 Result generation: on the accepted input at phase DECIM-1, the result is (accumulator + iv_din) arithmetically shifted right by log2(DECIM) (truncation toward minus infinity), and the result is written to the FIFO on that same edge.
REQ-022 DECIM=1: every accepted input is written unchanged.
REQ-023 Latency: o_dout_valid is high in the cycle after the edge that writes into an empty FIFO.
REQ-024 FIFO ordering: strict FIFO; ov_dout always shows the head entry; a read pops on the edge.
REQ-025 Write when full: a write with ov_level=FIFO_DEPTH and no simultaneous read drops the result and sets o_overflow on that edge.
REQ-026 Simultaneous write and read when full: the write is accepted and ov_level stays FIFO_DEPTH.
REQ-027 Read when empty: no effect, because o_dout_valid is low.
REQ-028 Simultaneous write and read at any level: ov_level is unchanged.
REQ-029 Overflow flag priority: i_clr_ovf clears o_overflow unless a drop occurs in the same cycle; a drop has priority.
REQ-030 Output-side independence: i_en does not gate the output side; draining continues while i_en=0.
REQ-031 Pointer wrap: pointers wrap modulo FIFO_DEPTH with no bubble.

Reset
REQ-032 Reset asserted: i_rst_n=0 immediately clears the phase counter, accumulator, FIFO pointers, ov_level and o_overflow, and drives o_dout_valid=0 and ov_dout=0.
REQ-033 Partial decimation group: reset during a partial group discards that group; the first accepted input after release is phase 0.
REQ-034 Reset release: release is synchronised externally; the block requires no internal synchroniser.

Structure
REQ-035 Shared package fir_pkg: holds the DATA_WIDTH default, the clog2 function, and the legal-value checks for DECIM and FIFO_DEPTH; elaboration fails on an illegal value.
REQ-036 Sub-module sync_fifo: one instance, parameterised by width and depth, with async active-low reset; decimation logic stays in fir_decimator.

Verification
REQ-037 Basic average: DECIM=4, inputs 4, 8, 12, 16 with i_dout_ready=1 -> one output of 10, valid one cycle after the 4th input.
REQ-038 Negative truncation: DECIM=4, inputs -1, -1, -1, -2 -> output -2 (sum -5 shifted right by 2).
REQ-039 Gap tolerance: DECIM=2, inputs 100, then i_din_valid low for 3 cycles, then 50 -> output 75; no output during the gap; i_en=0 with valid inputs is ignored.
REQ-040 Overflow: FIFO_DEPTH=4, i_dout_ready=0, 5 groups -> ov_level=4, o_overflow=1, and the drained sequence holds the first 4 results; a simultaneous drop and i_clr_ovf leaves the flag at 1.
REQ-041 Full with read: FIFO_DEPTH=4 full, with a write and read on the same edge -> no overflow, ov_level=4, and order preserved.
REQ-042 Mid-group reset: DECIM=4, two inputs, i_rst_n pulsed low mid-cycle -> outputs 0 immediately; a fresh group 1, 1, 1, 1 -> output 1.
